// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV64I multicycle control FSM and its decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_WB_ALU = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_MEM = 4'd8,
    S_BR_CMP = 4'd9,
    S_BR_TGT = 4'd10,
    S_JAL    = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_JAL = 3'd5,
    CLS_ILL = 3'd6
  } cls_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] CMD_FUNCT = 4'b0000;
  localparam logic [3:0] CMD_ADD   = 4'b0001;
  localparam logic [3:0] CMD_SUB   = 4'b0011;

  localparam logic [1:0] SRC_A_RS1   = 2'd0;
  localparam logic [1:0] SRC_A_PC    = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC  = 2'd2;

  localparam logic [2:0] F3_LD_SD = 3'b011;

  // add/sub, xor, or, and are the only ALU ops this core implements
  function automatic logic alu_funct3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-to-datapath bundle: IR fields, ALU flags, memory handshake and datapath strobes.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       ir_load;
  logic       pc_load;
  logic       aluout_load;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_cmd;
  logic [2:0] alu_funct3;
  logic [6:0] alu_funct7;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       halted;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct3, funct7, alu_flags, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_load, pc_load, aluout_load,
           alu_src_a, alu_src_b, alu_cmd, alu_funct3, alu_funct7,
           rf_we, wb_sel, halted, state_dbg
  );

  modport slave (
    output opcode, funct3, funct7, alu_flags, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_load, pc_load, aluout_load,
           alu_src_a, alu_src_b, alu_cmd, alu_funct3, alu_funct7,
           rf_we, wb_sel, halted, state_dbg
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/funct fields -> class and legality.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output cls_t       o_cls,
  output logic       o_legal
);

  always_comb begin
    o_cls   = CLS_ILL;
    o_legal = 1'b0;
    case (i_opcode)
      OP_R: begin
        o_cls   = CLS_R;
        // funct7 0100000 only selects sub, so it is legal with funct3 000 alone
        o_legal = alu_funct3_ok(i_funct3) &&
                  ((i_funct7 == 7'b0000000) ||
                   ((i_funct7 == 7'b0100000) && (i_funct3 == 3'b000)));
      end
      OP_I: begin
        o_cls   = CLS_I;
        o_legal = alu_funct3_ok(i_funct3);
      end
      OP_LD: begin
        o_cls   = CLS_LD;
        o_legal = (i_funct3 == F3_LD_SD);
      end
      OP_ST: begin
        o_cls   = CLS_ST;
        o_legal = (i_funct3 == F3_LD_SD);
      end
      OP_BR: begin
        o_cls   = CLS_BR;
        o_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001);
      end
      OP_JAL: begin
        o_cls   = CLS_JAL;
        o_legal = 1'b1;
      end
      default: begin
        o_cls   = CLS_ILL;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch, PC+4, execute, memory access and write-back for the RV64I core.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  if (XLEN != 64) begin : g_xlen_check
    $error("multicycle_ctrl sequences RV64I only; XLEN must be 64");
  end

  state_t     r_state, w_next;
  logic       r_zero_q;
  logic       w_zero_ld;
  cls_t       w_cls;
  logic       w_legal;
  logic [3:0] w_cmd;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  ctrl_decode u_decode (
    .i_opcode (bus.opcode),
    .i_funct3 (bus.funct3),
    .i_funct7 (bus.funct7),
    .o_cls    (w_cls),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_zero_q <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_zero_ld) r_zero_q <= bus.alu_flags[0];
    end
  end

  always_comb begin
    w_next           = r_state;
    w_zero_ld        = 1'b0;
    w_cmd            = CMD_FUNCT;
    w_f3             = 3'b000;
    w_f7             = 7'b0000000;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_load      = 1'b0;
    bus.pc_load      = 1'b0;
    bus.aluout_load  = 1'b0;
    bus.alu_src_a    = SRC_A_RS1;
    bus.alu_src_b    = SRC_B_RS2;
    bus.rf_we        = 1'b0;
    bus.wb_sel       = WB_SEL_ALU;
    bus.halted       = 1'b0;
    // Reset cycle keeps every strobe low so an abandoned access is dropped at once
    if (!rst_n) begin
      w_next = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_load = 1'b1;
            w_next      = S_DECODE;
          end
        end
        S_DECODE: begin
          bus.alu_src_a = SRC_A_PC;
          bus.alu_src_b = SRC_B_FOUR;
          w_cmd         = CMD_ADD;
          bus.pc_load   = 1'b1;
          if (!w_legal) begin
            w_next = S_HALT;
          end else begin
            case (w_cls)
              CLS_R:   w_next = S_EXEC_R;
              CLS_I:   w_next = S_EXEC_I;
              CLS_LD,
              CLS_ST:  w_next = S_ADDR;
              CLS_BR:  w_next = S_BR_CMP;
              CLS_JAL: w_next = S_JAL;
              default: w_next = S_HALT;
            endcase
          end
        end
        S_EXEC_R: begin
          w_f3            = bus.funct3;
          w_f7            = bus.funct7;
          bus.aluout_load = 1'b1;
          w_next          = S_WB_ALU;
        end
        S_EXEC_I: begin
          // funct7 stays 0: imm[11:5] of a negative immediate must not pick sub
          bus.alu_src_b   = SRC_B_IMM;
          w_f3            = bus.funct3;
          bus.aluout_load = 1'b1;
          w_next          = S_WB_ALU;
        end
        S_WB_ALU: begin
          bus.rf_we  = 1'b1;
          bus.wb_sel = WB_SEL_ALU;
          w_next     = S_FETCH;
        end
        S_ADDR: begin
          bus.alu_src_b   = SRC_B_IMM;
          w_cmd           = CMD_ADD;
          bus.aluout_load = 1'b1;
          w_next          = (w_cls == CLS_ST) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          if (bus.mem_ready) w_next = S_WB_MEM;
        end
        S_MEM_WR: begin
          bus.mem_req      = 1'b1;
          bus.mem_we       = 1'b1;
          bus.mem_addr_sel = 1'b1;
          if (bus.mem_ready) w_next = S_FETCH;
        end
        S_WB_MEM: begin
          bus.rf_we  = 1'b1;
          bus.wb_sel = WB_SEL_MEM;
          w_next     = S_FETCH;
        end
        S_BR_CMP: begin
          w_cmd     = CMD_SUB;
          w_zero_ld = 1'b1;
          w_next    = S_BR_TGT;
        end
        S_BR_TGT: begin
          bus.alu_src_a = SRC_A_OLDPC;
          bus.alu_src_b = SRC_B_IMM;
          w_cmd         = CMD_ADD;
          // funct3[0] distinguishes bne from beq
          bus.pc_load   = bus.funct3[0] ? ~r_zero_q : r_zero_q;
          w_next        = S_FETCH;
        end
        S_JAL: begin
          bus.alu_src_a = SRC_A_OLDPC;
          bus.alu_src_b = SRC_B_IMM;
          w_cmd         = CMD_ADD;
          bus.pc_load   = 1'b1;
          bus.rf_we     = 1'b1;
          bus.wb_sel    = WB_SEL_PC;
          w_next        = S_FETCH;
        end
        S_HALT: begin
          bus.halted = 1'b1;
        end
        default: w_next = S_HALT;
      endcase
    end
  end

  // The ALU picks its result by funct3, so fixed commands must present zeroed funct fields
  assign bus.alu_cmd    = w_cmd;
  assign bus.alu_funct3 = (w_cmd == CMD_FUNCT) ? w_f3 : 3'b000;
  assign bus.alu_funct7 = (w_cmd == CMD_FUNCT) ? w_f7 : 7'b0000000;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle checks of strobes and state through each instruction class.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle inputs shortly after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.opcode    = 7'd0;
    bus.funct3    = 3'd0;
    bus.funct7    = 7'd0;
    bus.alu_flags = 4'd0;
    bus.mem_ready = 1'b0;
    cyc(); cyc();
    settle();
    chk("rst_state", bus.state_dbg, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_memreq", bus.mem_req, 0);
    rst_n = 1'b1;

    // sub x3,x1,x2 with zero-wait memory
    instr(7'b0110011, 3'b000, 7'b0100000);
    bus.mem_ready = 1'b1;
    settle();
    chk("subF_state", bus.state_dbg, 0);
    chk("subF_req", bus.mem_req, 1);
    chk("subF_irld", bus.ir_load, 1);
    cyc(); settle();
    chk("subD_state", bus.state_dbg, 1);
    chk("subD_pcld", bus.pc_load, 1);
    chk("subD_cmd", bus.alu_cmd, 4'b0001);
    chk("subD_srca", bus.alu_src_a, 1);
    chk("subD_srcb", bus.alu_src_b, 2);
    chk("subD_memreq", bus.mem_req, 0);
    cyc(); settle();
    chk("subE_state", bus.state_dbg, 2);
    chk("subE_cmd", bus.alu_cmd, 4'b0000);
    chk("subE_f3", bus.alu_funct3, 3'b000);
    chk("subE_f7", bus.alu_funct7, 7'b0100000);
    chk("subE_aluld", bus.aluout_load, 1);
    chk("subE_rfwe", bus.rf_we, 0);
    cyc(); settle();
    chk("subW_rfwe", bus.rf_we, 1);
    chk("subW_wbsel", bus.wb_sel, 0);
    cyc(); settle();
    chk("sub_cycle5_fetch", bus.state_dbg, 0);

    // addi x1,x0,-1: imm[11:5] = 1111111 appears on funct7
    instr(7'b0010011, 3'b000, 7'b1111111);
    cyc(); settle();
    chk("addiD_state", bus.state_dbg, 1);
    cyc(); settle();
    chk("addiE_state", bus.state_dbg, 3);
    chk("addiE_f7", bus.alu_funct7, 0);
    chk("addiE_srcb", bus.alu_src_b, 1);
    chk("addiE_cmd", bus.alu_cmd, 0);
    cyc(); settle();
    chk("addiW_rfwe", bus.rf_we, 1);
    cyc();

    // ld with 3 wait cycles on the data access
    instr(7'b0000011, 3'b011, 7'd0);
    settle();
    chk("ld_c1_fetch", bus.state_dbg, 0);
    cyc(); settle();
    chk("ld_c2_decode", bus.state_dbg, 1);
    cyc(); settle();
    chk("ldA_state", bus.state_dbg, 5);
    chk("ldA_cmd", bus.alu_cmd, 1);
    chk("ldA_srcb", bus.alu_src_b, 1);
    chk("ldA_aluld", bus.aluout_load, 1);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) bus.mem_ready = 1'b1;
      settle();
      chk($sformatf("ldM%0d_state", i), bus.state_dbg, 6);
      chk($sformatf("ldM%0d_req", i), bus.mem_req, 1);
      chk($sformatf("ldM%0d_asel", i), bus.mem_addr_sel, 1);
      chk($sformatf("ldM%0d_we", i), bus.mem_we, 0);
      chk($sformatf("ldM%0d_rfwe", i), bus.rf_we, 0);
    end
    cyc(); settle();
    chk("ldW_state", bus.state_dbg, 8);
    chk("ldW_rfwe", bus.rf_we, 1);
    chk("ldW_wbsel", bus.wb_sel, 1);
    chk("ldW_req", bus.mem_req, 0);
    cyc(); settle();
    chk("ld_c9_fetch", bus.state_dbg, 0);
    chk("ld_c9_rfwe", bus.rf_we, 0);

    // sd zero-wait
    instr(7'b0100011, 3'b011, 7'd0);
    cyc(); cyc(); settle();
    chk("sdA_state", bus.state_dbg, 5);
    cyc(); settle();
    chk("sdM_state", bus.state_dbg, 7);
    chk("sdM_we", bus.mem_we, 1);
    chk("sdM_asel", bus.mem_addr_sel, 1);
    cyc(); settle();
    chk("sd_c5_fetch", bus.state_dbg, 0);

    // beq, zero flag set during compare -> taken
    instr(7'b1100011, 3'b000, 7'd0);
    cyc(); cyc();
    bus.alu_flags = 4'b0001;
    settle();
    chk("beqC_state", bus.state_dbg, 9);
    chk("beqC_cmd", bus.alu_cmd, 4'b0011);
    chk("beqC_pcld", bus.pc_load, 0);
    cyc();
    bus.alu_flags = 4'b0000;
    settle();
    chk("beqT_state", bus.state_dbg, 10);
    chk("beqT_pcld", bus.pc_load, 1);
    chk("beqT_srca", bus.alu_src_a, 2);
    cyc();

    // bne with the same zero flag -> not taken
    instr(7'b1100011, 3'b001, 7'd0);
    cyc(); cyc();
    bus.alu_flags = 4'b0001;
    settle();
    chk("bneC_cmd", bus.alu_cmd, 4'b0011);
    cyc();
    bus.alu_flags = 4'b0000;
    settle();
    chk("bneT_pcld", bus.pc_load, 0);
    cyc();

    // jal: 3 cycles
    instr(7'b1101111, 3'b000, 7'd0);
    cyc(); cyc(); settle();
    chk("jal_state", bus.state_dbg, 11);
    chk("jal_rfwe", bus.rf_we, 1);
    chk("jal_wbsel", bus.wb_sel, 2);
    chk("jal_pcld", bus.pc_load, 1);
    chk("jal_srca", bus.alu_src_a, 2);
    cyc(); settle();
    chk("jal_c4_fetch", bus.state_dbg, 0);

    // reset asserted in MEM_RD while the access is still waiting
    instr(7'b0000011, 3'b011, 7'd0);
    cyc(); cyc();
    bus.mem_ready = 1'b0;
    cyc(); settle();
    chk("rstM_state", bus.state_dbg, 6);
    rst_n = 1'b0;
    cyc(); settle();
    chk("rstM_req", bus.mem_req, 0);
    chk("rstM_state_fetch", bus.state_dbg, 0);
    chk("rstM_halted", bus.halted, 0);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;

    // R with funct7 0100000 and funct3 100 is illegal
    instr(7'b0110011, 3'b100, 7'b0100000);
    cyc(); cyc(); settle();
    chk("illR_state", bus.state_dbg, 12);
    chk("illR_halted", bus.halted, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;

    // lui is not supported -> HALT, no further memory requests until reset
    instr(7'b0110111, 3'b000, 7'd0);
    cyc(); cyc(); settle();
    chk("lui_state", bus.state_dbg, 12);
    chk("lui_halted", bus.halted, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk($sformatf("lui_hold%0d_req", i), bus.mem_req, 0);
      chk($sformatf("lui_hold%0d_halted", i), bus.halted, 1);
    end
    rst_n = 1'b0;
    cyc(); settle();
    chk("lui_rst_halted", bus.halted, 0);
    chk("lui_rst_state", bus.state_dbg, 0);
    rst_n = 1'b1;
    settle();
    chk("post_rst_fetch_req", bus.mem_req, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
